// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit adder/subtractor with valid/ready flow control.
// Each stage resolves one CHUNK-bit slice plus the carry registered by the stage before it.
module pipelined_adder #(
   parameter int WIDTH  = 16,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_sub,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH:0]   out_sum
);
   localparam int CHUNK = WIDTH / STAGES;

   if ((WIDTH % STAGES) != 0) begin : g_bad_split
      $error("pipelined_adder: WIDTH must be a multiple of STAGES");
   end

   logic advance_s;
   logic accept_s;

   assign advance_s = ~g_stage[STAGES-1].valid_q | out_ready;
   assign in_ready  = advance_s & ~flush;
   assign accept_s  = in_valid & in_ready;
   assign out_valid = g_stage[STAGES-1].valid_q;
   assign out_sum   = {g_stage[STAGES-1].carry_q, g_stage[STAGES-1].sum_q};

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      // Operand bits still unconsumed when entering stage k: chunks k..STAGES-1.
      localparam int REM = WIDTH - k * CHUNK;
      localparam int RES = (k + 1) * CHUNK;

      logic [REM-1:0]   a_s;
      logic [REM-1:0]   b_s;
      logic             cin_s;
      logic             sub_s;
      logic             vin_s;
      logic [CHUNK:0]   chunk_s;
      logic [RES-1:0]   sum_d;
      logic             carry_d;
      logic             load_s;

      logic             valid_q;
      logic [RES-1:0]   sum_q;
      logic             carry_q;

      if (k == 0) begin : g_head
         assign a_s   = in_a;
         assign b_s   = in_sub ? ~in_b : in_b;
         assign cin_s = in_sub;
         assign sub_s = in_sub;
         assign vin_s = accept_s;
         assign sum_d = chunk_s[CHUNK-1:0];
      end else begin : g_body
         assign a_s   = g_stage[k-1].g_skew.a_q;
         assign b_s   = g_stage[k-1].g_skew.b_q;
         assign cin_s = g_stage[k-1].carry_q;
         assign sub_s = g_stage[k-1].g_skew.sub_q;
         assign vin_s = g_stage[k-1].valid_q;
         assign sum_d = {chunk_s[CHUNK-1:0], g_stage[k-1].sum_q};
      end

      assign chunk_s = {1'b0, a_s[CHUNK-1:0]} + {1'b0, b_s[CHUNK-1:0]} + {{CHUNK{1'b0}}, cin_s};
      // The final carry becomes the result MSB; subtraction inverts it into a borrow flag.
      assign carry_d = (k == STAGES - 1) ? (chunk_s[CHUNK] ^ sub_s) : chunk_s[CHUNK];
      assign load_s  = advance_s & ~flush & vin_s;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            valid_q <= 1'b0;
         end else if (flush) begin
            valid_q <= 1'b0;
         end else if (advance_s) begin
            valid_q <= vin_s;
         end
      end

      // Data only moves with a valid beat, so the output register holds across bubbles and flushes.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            sum_q   <= {RES{1'b0}};
            carry_q <= 1'b0;
         end else if (load_s) begin
            sum_q   <= sum_d;
            carry_q <= carry_d;
         end
      end

      if (k < STAGES - 1) begin : g_skew
         logic [REM-CHUNK-1:0] a_q;
         logic [REM-CHUNK-1:0] b_q;
         logic                 sub_q;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               a_q   <= {(REM-CHUNK){1'b0}};
               b_q   <= {(REM-CHUNK){1'b0}};
               sub_q <= 1'b0;
            end else if (load_s) begin
               a_q   <= a_s[REM-1:CHUNK];
               b_q   <= b_s[REM-1:CHUNK];
               sub_q <= sub_s;
            end
         end
      end
   end
endmodule

// File: tb/tb_pipelined_adder.sv
// Directed and scoreboarded bench for pipelined_adder (16/4 main build, plus 16/1 and 32/8 builds).
module tb_pipelined_adder;
   logic        clk = 1'b0;
   logic        rst_n, flush;
   logic        in_valid, in_ready, in_sub, out_valid, out_ready;
   logic [15:0] in_a, in_b;
   logic [16:0] out_sum;

   logic        iv1, ir1, ov1;
   logic [15:0] a1;
   logic [16:0] s1;
   logic        iv8, ir8, ov8;
   logic [31:0] a8;
   logic [32:0] s8;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pipelined_adder #(.WIDTH(16), .STAGES(4)) u_dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_sub(in_sub), .in_a(in_a), .in_b(in_b), .out_valid(out_valid),
      .out_ready(out_ready), .out_sum(out_sum));

   pipelined_adder #(.WIDTH(16), .STAGES(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .flush(1'b0), .in_valid(iv1), .in_ready(ir1),
      .in_sub(1'b0), .in_a(a1), .in_b(16'h0001), .out_valid(ov1),
      .out_ready(1'b1), .out_sum(s1));

   pipelined_adder #(.WIDTH(32), .STAGES(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .flush(1'b0), .in_valid(iv8), .in_ready(ir8),
      .in_sub(1'b0), .in_a(a8), .in_b(32'h0000_0001), .out_valid(ov8),
      .out_ready(1'b1), .out_sum(s8));

   function automatic logic [16:0] ref_sum(input logic [15:0] a, input logic [15:0] b, input logic sub);
      return sub ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
   endfunction

   task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] b, input logic sub);
      in_valid = v; in_a = a; in_b = b; in_sub = sub;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
      drive(1'b0, 16'h0000, 16'h0000, 1'b0);
      iv1 = 1'b0; a1 = 16'h0000; iv8 = 1'b0; a8 = 32'h0000_0000;
      #12;
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
      checks++;
      if (out_sum !== 17'h00000) begin errors++; $display("FAIL reset_sum got %h want 00000", out_sum); end
      @(negedge clk); rst_n = 1'b1; #1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", in_ready); end
   endtask

   task automatic test_carry_ripple();
      out_ready = 1'b1;
      drive(1'b1, 16'hFFFF, 16'h0001, 1'b0);
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         in_valid = 1'b0;
         checks++;
         if (out_valid !== (i == 4)) begin
            errors++; $display("FAIL ripple_latency cycle %0d got %b want %b", i, out_valid, (i == 4));
         end
      end
      checks++;
      if (out_sum !== 17'h10000) begin errors++; $display("FAIL ripple_sum got %h want 10000", out_sum); end
   endtask

   task automatic test_sub();
      drive(1'b1, 16'h0003, 16'h0005, 1'b1);
      @(negedge clk); drive(1'b1, 16'h0005, 16'h0003, 1'b1);
      @(negedge clk); drive(1'b0, 16'h0000, 16'h0000, 1'b0);
      repeat (2) @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_sum !== 17'h1FFFE) begin
         errors++; $display("FAIL sub_borrow got v=%b %h want v=1 1fffe", out_valid, out_sum);
      end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_sum !== 17'h00002) begin
         errors++; $display("FAIL sub_plain got v=%b %h want v=1 00002", out_valid, out_sum);
      end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      logic [16:0] exp_q[$];
      logic [16:0] exp;
      int sent = 0;
      int got = 0;
      int cyc = 0;
      while ((sent < 300 || exp_q.size() != 0) && cyc < 5000) begin
         drive((sent < 300) && ($urandom_range(0, 9) != 0), 16'($urandom), 16'($urandom),
               1'($urandom_range(0, 1)));
         out_ready = ($urandom_range(0, 3) != 0);
         #1;
         if (out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++; $display("FAIL b2b_extra got %h want nothing", out_sum);
            end else begin
               exp = exp_q.pop_front();
               got++;
               if (out_sum !== exp) begin errors++; $display("FAIL b2b_data beat %0d got %h want %h", got, out_sum, exp); end
            end
         end
         if (in_valid && in_ready) begin
            exp_q.push_back(ref_sum(in_a, in_b, in_sub));
            sent++;
         end
         @(negedge clk);
         cyc++;
      end
      drive(1'b0, 16'h0000, 16'h0000, 1'b0);
      out_ready = 1'b1;
      checks++;
      if (got != 300) begin errors++; $display("FAIL b2b_count got %0d want 300", got); end
      @(negedge clk);
   endtask

   task automatic test_stall();
      logic [15:0] ta[4] = '{16'h1234, 16'hFFFF, 16'h8000, 16'h0001};
      logic [15:0] tb[4] = '{16'h4321, 16'h0001, 16'h8000, 16'h0002};
      logic        ts[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
      out_ready = 1'b0;
      for (int j = 0; j < 4; j++) begin
         drive(1'b1, ta[j], tb[j], ts[j]);
         @(negedge clk);
      end
      drive(1'b1, 16'hDEAD, 16'hBEEF, 1'b0);
      for (int i = 0; i < 10; i++) begin
         #1;
         checks++;
         if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_ready cycle %0d got %b want 0", i, in_ready); end
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b1 || out_sum !== 17'h05555) begin
            errors++; $display("FAIL stall_hold cycle %0d got v=%b %h want v=1 05555", i, out_valid, out_sum);
         end
      end
      drive(1'b0, 16'h0000, 16'h0000, 1'b0);
      out_ready = 1'b1;
      for (int j = 0; j < 4; j++) begin
         checks++;
         if (out_valid !== 1'b1 || out_sum !== ref_sum(ta[j], tb[j], ts[j])) begin
            errors++; $display("FAIL stall_drain beat %0d got v=%b %h want v=1 %h", j, out_valid, out_sum,
                               ref_sum(ta[j], tb[j], ts[j]));
         end
         @(negedge clk);
      end
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_empty got %b want 0", out_valid); end
   endtask

   task automatic test_flush();
      logic leaked = 1'b0;
      out_ready = 1'b1;
      for (int j = 0; j < 3; j++) begin
         drive(1'b1, 16'h0100 + 16'(j), 16'h0011, 1'b0);
         @(negedge clk);
      end
      drive(1'b1, 16'h0200, 16'h0022, 1'b0);
      flush = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_ready got %b want 0", in_ready); end
      @(negedge clk);
      flush = 1'b0;
      drive(1'b0, 16'h0000, 16'h0000, 1'b0);
      checks++;
      if (out_valid !== 1'b0 || out_sum !== 17'h1FFFF) begin
         errors++; $display("FAIL flush_clear got v=%b %h want v=0 1ffff", out_valid, out_sum);
      end
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (out_valid !== 1'b0) leaked = 1'b1;
      end
      checks++;
      if (leaked !== 1'b0) begin errors++; $display("FAIL flush_leak got %b want 0", leaked); end
   endtask

   task automatic test_reset_mid();
      logic leaked = 1'b0;
      out_ready = 1'b0;
      for (int j = 0; j < 4; j++) begin
         drive(1'b1, 16'h00AA, 16'h0055, 1'b0);
         @(negedge clk);
      end
      drive(1'b0, 16'h0000, 16'h0000, 1'b0);
      checks++;
      if (out_valid !== 1'b1 || out_sum !== 17'h000FF) begin
         errors++; $display("FAIL rstmid_full got v=%b %h want v=1 000ff", out_valid, out_sum);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_sum !== 17'h00000) begin
         errors++; $display("FAIL rstmid_async got v=%b %h want v=0 00000", out_valid, out_sum);
      end
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (out_valid !== 1'b0) leaked = 1'b1;
      end
      checks++;
      if (leaked !== 1'b0) begin errors++; $display("FAIL rstmid_leak got %b want 0", leaked); end
   endtask

   task automatic test_other_builds();
      iv1 = 1'b1; a1 = 16'hFFFF;
      iv8 = 1'b1; a8 = 32'hFFFF_FFFF;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         iv1 = 1'b0; iv8 = 1'b0;
         checks++;
         if (ov1 !== (i == 1)) begin errors++; $display("FAIL s1_latency cycle %0d got %b want %b", i, ov1, (i == 1)); end
         checks++;
         if (ov8 !== (i == 8)) begin errors++; $display("FAIL s8_latency cycle %0d got %b want %b", i, ov8, (i == 8)); end
         if (i == 1) begin
            checks++;
            if (s1 !== 17'h10000) begin errors++; $display("FAIL s1_sum got %h want 10000", s1); end
         end
         if (i == 8) begin
            checks++;
            if (s8 !== 33'h1_0000_0000) begin errors++; $display("FAIL s8_sum got %h want 100000000", s8); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_carry_ripple();
      test_sub();
      test_back_to_back();
      test_stall();
      test_flush();
      test_reset_mid();
      test_other_builds();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
